// File: rtl/gmii_tx_arb.sv
// gmii_tx_arb: two-source GMII transmit arbiter with preamble/SFD insertion,
// underrun abort with drain, and a programmable inter-frame gap.
// Optional per-source frame and abort counters: define GMII_TX_ARB_STAT_EN.
module gmii_tx_arb #(
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic       gmii_tx_clk,
    input  logic       rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       underrun,
    output logic       busy
`ifdef GMII_TX_ARB_STAT_EN
    ,
    output logic [15:0] frames0,
    output logic [15:0] frames1,
    output logic [15:0] underruns
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_IFG      = 3'd4
    } state_t;

    // Last counter value before leaving the state.
    localparam logic [2:0] PRE_LAST = 3'd6;
    localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 32'd1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;          // 0 = source 0, 1 = source 1
    logic        last_grant_q, last_grant_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  txd_q, txd_d;
    logic        underrun_q, underrun_d;

    logic        sel_valid_s;
    logic [7:0]  sel_data_s;
    logic        sel_last_s;
    logic        accept_phase_s;

    assign sel_valid_s    = grant_q ? s1_valid : s0_valid;
    assign sel_data_s     = grant_q ? s1_data  : s0_data;
    assign sel_last_s     = grant_q ? s1_last  : s0_last;
    // Ready is withheld while reset is asserted so no byte is lost to the reset edge.
    assign accept_phase_s = ((state_q == ST_PAYLOAD) || (state_q == ST_DRAIN)) && !rst;

    assign s0_ready   = accept_phase_s && !grant_q;
    assign s1_ready   = accept_phase_s &&  grant_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_txd   = txd_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != ST_IDLE);

    // Next-state, grant, counters and next registered GMII outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pre_cnt_d    = pre_cnt_q;
        ifg_cnt_d    = ifg_cnt_q;
        tx_en_d      = 1'b0;
        txd_d        = 8'h00;
        underrun_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    if (s0_valid && s1_valid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = s1_valid;
                    end
                    last_grant_d = grant_d;
                    state_d      = ST_PREAMBLE;
                    pre_cnt_d    = 3'd0;
                    tx_en_d      = 1'b1;
                    txd_d        = 8'h55;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                if (pre_cnt_q == PRE_LAST) begin
                    txd_d     = 8'hD5;
                    state_d   = ST_PAYLOAD;
                    pre_cnt_d = 3'd0;
                end else begin
                    txd_d     = 8'h55;
                    pre_cnt_d = pre_cnt_q + 3'd1;
                end
            end
            ST_PAYLOAD: begin
                if (sel_valid_s) begin
                    tx_en_d = 1'b1;
                    txd_d   = sel_data_s;
                    if (sel_last_s) begin
                        state_d   = ST_IFG;
                        ifg_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    underrun_d = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sel_valid_s && sel_last_s) begin
                    state_d   = ST_IFG;
                    ifg_cnt_d = 8'd0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d   = ST_IDLE;
                    ifg_cnt_d = 8'd0;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pre_cnt_d = 3'd0;
                ifg_cnt_d = 8'd0;
            end
        endcase
    end

    // State, grant, counters and GMII output registers.
    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pre_cnt_q    <= 3'd0;
            ifg_cnt_q    <= 8'd0;
            tx_en_q      <= 1'b0;
            txd_q        <= 8'h00;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pre_cnt_q    <= pre_cnt_d;
            ifg_cnt_q    <= ifg_cnt_d;
            tx_en_q      <= tx_en_d;
            txd_q        <= txd_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef GMII_TX_ARB_STAT_EN
    logic        frame_done_s;
    logic        abort_s;
    logic [15:0] frames0_q;
    logic [15:0] frames1_q;
    logic [15:0] underruns_q;

    assign frame_done_s = (state_q == ST_PAYLOAD) && sel_valid_s && sel_last_s;
    assign abort_s      = (state_q == ST_PAYLOAD) && !sel_valid_s;
    assign frames0      = frames0_q;
    assign frames1      = frames1_q;
    assign underruns    = underruns_q;

    // Completed-frame and aborted-frame counters; they wrap naturally at 16 bits.
    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            frames0_q   <= 16'd0;
            frames1_q   <= 16'd0;
            underruns_q <= 16'd0;
        end else begin
            if (frame_done_s && !grant_q) begin
                frames0_q <= frames0_q + 16'd1;
            end else begin
                frames0_q <= frames0_q;
            end
            if (frame_done_s && grant_q) begin
                frames1_q <= frames1_q + 16'd1;
            end else begin
                frames1_q <= frames1_q;
            end
            if (abort_s) begin
                underruns_q <= underruns_q + 16'd1;
            end else begin
                underruns_q <= underruns_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gmii_tx_arb.sv
// Testbench for gmii_tx_arb: timeline model of the link plus literal frame checks.
module tb_gmii_tx_arb;

    localparam int IFG = 12;

    logic       clk = 1'b0;
    logic       rst, rst3;
    logic       s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
    logic [7:0] s0_data, s1_data;
    logic       gmii_tx_en, underrun, busy;
    logic [7:0] gmii_txd;
    logic       s3_valid, s3_last, s3_ready, z_ready, en3, ur3, busy3;
    logic [7:0] s3_data, txd3;
`ifdef GMII_TX_ARB_STAT_EN
    logic [15:0] frames0, frames1, underruns, f0_3, f1_3, ur_3;
`endif

    always #5 clk = ~clk;

    gmii_tx_arb #(.IFG_CYCLES(IFG)) u_dut (
        .gmii_tx_clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
        .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .underrun(underrun), .busy(busy)
`ifdef GMII_TX_ARB_STAT_EN
        , .frames0(frames0), .frames1(frames1), .underruns(underruns)
`endif
    );

    gmii_tx_arb #(.IFG_CYCLES(3)) u_dut3 (
        .gmii_tx_clk(clk), .rst(rst3),
        .s0_valid(s3_valid), .s0_data(s3_data), .s0_last(s3_last), .s0_ready(s3_ready),
        .s1_valid(1'b0), .s1_data(8'h00), .s1_last(1'b0), .s1_ready(z_ready),
        .gmii_tx_en(en3), .gmii_txd(txd3), .underrun(ur3), .busy(busy3)
`ifdef GMII_TX_ARB_STAT_EN
        , .frames0(f0_3), .frames1(f1_3), .underruns(ur_3)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       bubble;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: when the link is owned, and what it carries ----------------
    int          e_idx = 0;
    bit          m_ok = 1'b0, m_act = 1'b0, m_drain = 1'b0;
    int          m_own = 0, m_last = 1, m_g = 0, m_free = 0, m_k = 0;
    logic        m_en = 1'b0, m_ur = 1'b0, m_busy = 1'b0, m_r0 = 1'b0, m_r1 = 1'b0;
    logic [7:0]  m_txd = 8'h00;
    logic        m_v, m_l;
    logic [7:0]  m_d;
    logic [15:0] m_f0 = 16'd0, m_f1 = 16'd0, m_urn = 16'd0;

    always @(posedge clk) begin
        m_en  = 1'b0;
        m_txd = 8'h00;
        m_ur  = 1'b0;
        if (rst) begin
            m_ok = 1'b1; m_act = 1'b0; m_drain = 1'b0; m_last = 1; m_free = e_idx + 1;
            m_f0 = 16'd0; m_f1 = 16'd0; m_urn = 16'd0;
        end else if (!m_act) begin
            if (e_idx >= m_free && (s0_valid || s1_valid)) begin
                m_own   = (s0_valid && s1_valid) ? (1 - m_last) : (s1_valid ? 1 : 0);
                m_last  = m_own;
                m_act   = 1'b1;
                m_drain = 1'b0;
                m_g     = e_idx;
                m_en    = 1'b1;
                m_txd   = 8'h55;
            end
        end else begin
            m_k = e_idx - m_g;
            m_v = (m_own == 1) ? s1_valid : s0_valid;
            m_l = (m_own == 1) ? s1_last  : s0_last;
            m_d = (m_own == 1) ? s1_data  : s0_data;
            if (m_k <= 7) begin
                m_en  = 1'b1;
                m_txd = (m_k == 7) ? 8'hD5 : 8'h55;
            end else if (!m_drain) begin
                if (m_v) begin
                    m_en  = 1'b1;
                    m_txd = m_d;
                    if (m_l) begin
                        m_act  = 1'b0;
                        m_free = e_idx + 1 + IFG;
                        if (m_own == 1) m_f1 = m_f1 + 16'd1;
                        else            m_f0 = m_f0 + 16'd1;
                    end
                end else begin
                    m_ur    = 1'b1;
                    m_drain = 1'b1;
                    m_urn   = m_urn + 16'd1;
                end
            end else if (m_v && m_l) begin
                m_act  = 1'b0;
                m_free = e_idx + 1 + IFG;
            end
        end
        m_busy = m_act || (e_idx < m_free - 1);
        e_idx++;
        m_r0 = m_act && ((e_idx - m_g) >= 8) && (m_own == 0);
        m_r1 = m_act && ((e_idx - m_g) >= 8) && (m_own == 1);
    end

    // ---------------- compare process and frame logger ----------------
    int         ncyc = 0, start_neg = 0, end_neg = 0, last_start = 0, ur_cnt = 0;
    bit         prev_en = 1'b0;
    logic [7:0] cur[$];
    logic [7:0] last_bytes[$];
    int         fl_len[$];
    int         fl_gap[$];
    logic [7:0] fl_p0[$];
    int         end3 = 0, g3[$];
    bit         prev3 = 1'b0, seen3 = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (m_ok) begin
            chk("tx_en",    {31'd0, gmii_tx_en}, {31'd0, m_en});
            chk("txd",      {24'd0, gmii_txd},   {24'd0, m_txd});
            chk("underrun", {31'd0, underrun},   {31'd0, m_ur});
            chk("busy",     {31'd0, busy},       {31'd0, m_busy});
            chk("s0_ready", {31'd0, s0_ready},   {31'd0, m_r0 && !rst});
            chk("s1_ready", {31'd0, s1_ready},   {31'd0, m_r1 && !rst});
`ifdef GMII_TX_ARB_STAT_EN
            chk("frames0",   {16'd0, frames0},   {16'd0, m_f0});
            chk("frames1",   {16'd0, frames1},   {16'd0, m_f1});
            chk("underruns", {16'd0, underruns}, {16'd0, m_urn});
`endif
        end
        if (gmii_tx_en === 1'b1 && !prev_en) begin
            cur.delete();
            start_neg = ncyc;
            fl_gap.push_back(ncyc - end_neg);
        end
        if (gmii_tx_en === 1'b1) cur.push_back(gmii_txd);
        if (gmii_tx_en !== 1'b1 && prev_en) begin
            end_neg = ncyc;
            fl_len.push_back(cur.size());
            fl_p0.push_back((cur.size() > 8) ? cur[8] : 8'h00);
            last_bytes = cur;
            last_start = start_neg;
        end
        prev_en = (gmii_tx_en === 1'b1);
        if (underrun === 1'b1) ur_cnt++;
        if (en3 === 1'b1 && !prev3 && seen3) g3.push_back(ncyc - end3);
        if (en3 !== 1'b1 && prev3) begin
            end3  = ncyc;
            seen3 = 1'b1;
        end
        prev3 = (en3 === 1'b1);
    end

    // ---------------- stimulus ----------------
    bit         hs0, hs1, hs3;
    bit         idx3 = 1'b0;
    logic [7:0] dat3 = 8'h00;

    task automatic drive_srcs();
        s0_valid = (q0.size() > 0) && !q0[0].bubble;
        s0_data  = (q0.size() > 0) ? q0[0].d : 8'h00;
        s0_last  = (q0.size() > 0) && q0[0].last;
        s1_valid = (q1.size() > 0) && !q1[0].bubble;
        s1_data  = (q1.size() > 0) ? q1[0].d : 8'h00;
        s1_last  = (q1.size() > 0) && q1[0].last;
    endtask

    task automatic tick();
        @(negedge clk);
        hs0 = s0_valid && s0_ready;
        hs1 = s1_valid && s1_ready;
        hs3 = s3_valid && s3_ready;
        @(posedge clk);
        #1;
        if (q0.size() > 0 && (hs0 || q0[0].bubble)) void'(q0.pop_front());
        if (q1.size() > 0 && (hs1 || q1[0].bubble)) void'(q1.pop_front());
        drive_srcs();
        if (hs3) begin
            idx3 = ~idx3;
            dat3 = dat3 + 8'd1;
        end
        s3_valid = !rst3;
        s3_data  = dat3;
        s3_last  = idx3;
    endtask

    task automatic push_frame(input int src, input logic [7:0] base, input logic [7:0] step,
                              input int n, input int bubble_after);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            if (i == bubble_after) begin
                e = '{d: 8'h00, last: 1'b0, bubble: 1'b1};
                if (src == 1) q1.push_back(e); else q0.push_back(e);
            end
            e = '{d: base + step * 8'(i), last: (i == n - 1), bubble: 1'b0};
            if (src == 1) q1.push_back(e); else q0.push_back(e);
        end
    endtask

    task automatic run_quiet(input int max_cyc);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_act || m_busy) && n < max_cyc) begin
            tick();
            n++;
        end
        if (n >= max_cyc) chk("timeout", 32'd1, 32'd0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    logic [7:0] exp_a[11];
    int         c0, nf, nu, guard;

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        s3_valid = 1'b0; s3_data = 8'h00; s3_last = 1'b0;
        drive_srcs();
        repeat (3) tick();
        rst = 1'b0; rst3 = 1'b0;
        tick();

        // Single frame 0x11,0x22,0x33 from s0 with valid held.
        for (int i = 0; i < 7; i++) exp_a[i] = 8'h55;
        exp_a[7] = 8'hD5; exp_a[8] = 8'h11; exp_a[9] = 8'h22; exp_a[10] = 8'h33;
        nf = fl_len.size();
        c0 = ncyc;
        push_frame(0, 8'h11, 8'h11, 3, -1);
        run_quiet(200);
        chk("a_len", 32'(fl_len[nf]), 32'd11);
        chk("a_start", 32'(last_start - c0), 32'd3);
        chk("a_txlow", 32'(end_neg - last_start), 32'd11);
        for (int i = 0; i < 11; i++) chk("a_byte", {24'd0, last_bytes[i]}, {24'd0, exp_a[i]});

        // Tie from reset: s0 then s1 with a 12-cycle gap; a second tie goes to s0.
        do_reset();
        nf = fl_len.size();
        push_frame(0, 8'hA0, 8'h01, 4, -1);
        push_frame(1, 8'hB0, 8'h01, 4, -1);
        run_quiet(400);
        push_frame(0, 8'hA8, 8'h01, 2, -1);
        push_frame(1, 8'hB8, 8'h01, 2, -1);
        run_quiet(400);
        chk("tie1_first",  {24'd0, fl_p0[nf]},     32'h0000_00A0);
        chk("tie1_second", {24'd0, fl_p0[nf + 1]}, 32'h0000_00B0);
        chk("tie1_gap",    32'(fl_gap[nf + 1]),    32'd12);
        chk("tie2_first",  {24'd0, fl_p0[nf + 2]}, 32'h0000_00A8);
        chk("tie2_second", {24'd0, fl_p0[nf + 3]}, 32'h0000_00B8);

        // Underrun: s1 stalls after 2 of 5 bytes while s0 waits its turn.
        nf = fl_len.size();
        nu = ur_cnt;
        push_frame(1, 8'hC0, 8'h01, 5, 2);
        tick();
        push_frame(0, 8'hD0, 8'h01, 2, -1);
        run_quiet(400);
        chk("ur_pulses", 32'(ur_cnt - nu),     32'd1);
        chk("ur_len",    32'(fl_len[nf]),      32'd10);
        chk("ur_gap",    32'(fl_gap[nf + 1]),  32'd16);
        chk("ur_next",   {24'd0, fl_p0[nf + 1]}, 32'h0000_00D0);

        // Reset while the 4th payload byte is offered; next frame starts cleanly.
        push_frame(0, 8'hE0, 8'h01, 6, -1);
        guard = 0;
        while (q0.size() > 3 && guard < 100) begin
            tick();
            guard++;
        end
        chk("rst_reach", {31'd0, guard < 100}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete();
        drive_srcs();
        @(negedge clk);
        chk("rst_txen", {31'd0, gmii_tx_en}, 32'd0);
        chk("rst_busy", {31'd0, busy},       32'd0);
        nf = fl_len.size();
        push_frame(0, 8'hF0, 8'h01, 3, -1);
        run_quiet(200);
        chk("post_rst_len", 32'(fl_len[nf]), 32'd11);
        for (int i = 0; i < 8; i++) chk("post_rst_pre", {24'd0, last_bytes[i]}, {24'd0, exp_a[i]});
        chk("post_rst_p0", {24'd0, last_bytes[8]}, 32'h0000_00F0);

        // Two more good s0 frames and one aborted s1 frame.
        push_frame(0, 8'h10, 8'h01, 2, -1);
        run_quiet(200);
        push_frame(0, 8'h20, 8'h01, 2, -1);
        run_quiet(200);
        push_frame(1, 8'h30, 8'h01, 3, 1);
        run_quiet(200);
`ifdef GMII_TX_ARB_STAT_EN
        chk("stat_frames0",   {16'd0, frames0},   32'd3);
        chk("stat_frames1",   {16'd0, frames1},   32'd0);
        chk("stat_underruns", {16'd0, underruns}, 32'd1);
`endif

        // Short-IFG instance: back-to-back s0 frames separated by exactly 3 idle cycles.
        chk("ifg3_count", {31'd0, g3.size() >= 3}, 32'd1);
        if (g3.size() >= 3) begin
            for (int i = 0; i < 3; i++) chk("ifg3_gap", 32'(g3[i]), 32'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gmii_tx_arb.md
GMII_TX_ARB -- requirements
Module: gmii_tx_arb

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, meaning the minimum number of idle cycles (gmii_tx_en low) between frames; legal range 1..255.
REQ-002 SHALL have port gmii_tx_clk, input, 1 bit: the GMII transmit clock; the only clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous to gmii_tx_clk, active-high.
REQ-004 SHALL have ports s0_valid and s1_valid, input, 1 bit each: the source has a payload byte and requests the link.
REQ-005 SHALL have ports s0_data and s1_data, input, 8 bits each: payload byte (destination MAC through FCS; no preamble).
REQ-006 SHALL have ports s0_last and s1_last, input, 1 bit each: the current byte is the final byte of the frame.
REQ-007 SHALL have ports s0_ready and s1_ready, output, 1 bit each: a byte is accepted at any rising edge where valid and ready are both high.
REQ-008 SHALL have port gmii_tx_en, output, 1 bit, registered: GMII data valid, feeding the RGMII transmit ODDR stage.
REQ-009 SHALL have port gmii_txd, output, 8 bits, registered: GMII data byte.
REQ-010 SHALL have port underrun, output, 1 bit: a one-cycle pulse when a frame is aborted.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, PREAMBLE, PAYLOAD, DRAIN and IFG.
REQ-013 In IDLE, an edge with any sN_valid high SHALL grant one source and enter PREAMBLE.
- If both sources are valid, grant the source not granted last (round-robin).
REQ-014 If valid is sampled at edge T, gmii_tx_en SHALL be 1 from T+1, with gmii_txd = 0x55 for T+1..T+7 and 0xD5 at T+8.
REQ-015 s_ready SHALL be combinational: high only for the granted source, and only in PAYLOAD or DRAIN; both readys SHALL be 0 otherwise.
REQ-016 In PAYLOAD, a byte accepted at edge E SHALL appear on gmii_txd with gmii_tx_en = 1 during the cycle following E.
- The first payload byte appears at T+9 when the source holds valid.
REQ-017 When a last byte is accepted, the FSM SHALL enter IFG.
- gmii_tx_en drops one cycle after that byte is output.
REQ-018 IFG SHALL hold gmii_tx_en = 0 and gmii_txd = 0x00 for exactly IFG_CYCLES cycles, then return to IDLE.
- A new grant is therefore possible only after IFG_CYCLES idle cycles.
REQ-019 If the granted valid is low at any PAYLOAD edge before last is accepted (underrun), the block SHALL do all of the following:
- drop gmii_tx_en on the next cycle;
- pulse underrun for one cycle;
- enter DRAIN.
REQ-020 DRAIN SHALL keep ready high and discard bytes until last is accepted, then enter IFG.
REQ-021 The grant SHALL be stable from the IDLE exit until the return to IDLE.
- The non-granted source's valid SHALL be ignored and its ready held at 0.
REQ-022 The preamble counter SHALL be 3 bits and the IFG counter 8 bits.
- Both counters clear on every state entry; neither wraps inside a state.
REQ-023 Whenever gmii_tx_en is 0, gmii_txd SHALL be 0x00.

Reset
REQ-024 Reset SHALL force the following on the first edge where rst is high, including mid-frame:
- state = IDLE;
- gmii_tx_en = 0, gmii_txd = 0x00, underrun = 0;
- both readys = 0, busy = 0;
- round-robin last-grant = source 1, so source 0 wins the first tie;
- all counters = 0.
REQ-025 A frame interrupted by reset SHALL NOT resume; the next frame after reset starts with a full preamble without an IFG.

Configuration
REQ-026 Macro GMII_TX_ARB_STAT_EN defined SHALL add the following outputs:
- 16-bit frames0 and frames1: increment on each completed, non-aborted frame per source;
- 16-bit underruns: increments per aborted frame.
All three counters wrap from 0xFFFF to 0 and reset to 0.
REQ-027 Without GMII_TX_ARB_STAT_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Single frame: s0 sends 0x11,0x22,0x33 (last) with valid held from edge T -> gmii_txd = 7×0x55, 0xD5, 0x11, 0x22, 0x33 at T+1..T+11; tx_en low at T+12.
REQ-029 Tie: s0 and s1 valid together from reset -> s0 frame first, then 12 idle cycles, then the s1 preamble; a second tie then grants s0 again.
REQ-030 Underrun: s1 drops valid after 2 of 5 bytes -> tx_en low the next cycle, one underrun pulse, remaining 3 bytes accepted and discarded, 12 IFG cycles.
REQ-031 IFG_CYCLES = 3, back-to-back s0 frames -> exactly 3 cycles with tx_en = 0 between the last payload byte and the next 0x55.
REQ-032 rst asserted during the 4th payload byte -> tx_en = 0 and busy = 0 the following cycle; the next frame begins with a full 8-byte preamble.
REQ-033 With GMII_TX_ARB_STAT_EN, 3 good s0 frames and 1 aborted s1 frame -> frames0 = 3, frames1 = 0, underruns = 1.
